// File: rtl/param_pc_serial_unit.sv
// Program counter with a bit-serial target deserializer and a serial PC / PC+4 streamer.
// Targets arrive LSB-first in P_NBITS subwords; streams leave LSB-first in the same subword width.
module param_pc_serial_unit #(
    parameter int          P_NBITS      = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h00080000,
    parameter bit          C_EXT        = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               addr_en,
    input  logic [P_NBITS-1:0] addr_in,
    input  logic               stream_start,
    input  logic               stream_en,
    input  logic               stream_sel,
    input  logic               commit,
    input  logic               commit_sel,
    output logic [31:0]        pc,
    output logic [P_NBITS-1:0] stream_out,
    output logic               stream_busy,
    output logic               stream_last,
    output logic               addr_full,
    output logic [31:0]        addr_reg,
    output logic               misalign_err
);

    localparam int N_SUB = 32 / P_NBITS;
    localparam int CW    = (N_SUB > 1) ? $clog2(N_SUB) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SUB - 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] addr_cnt_r, count_r;
    logic [31:0]   pc_r, addr_reg_r, sh_pc_r, sh_pc4_r;
    logic [31:0]   addr_wr_s, target_s, pc_plus4_s;
    logic          addr_full_r, misalign_r;
    logic          misaligned_s, addr_wr_en_s, load_s, advance_s;

    // A full-width rotate degenerates to identity when P_NBITS is 32.
    function automatic logic [31:0] rotr(input logic [31:0] x);
        return (x >> P_NBITS) | (x << (32 - P_NBITS));
    endfunction

    assign pc_plus4_s   = pc_r + 32'd4;
    assign target_s     = {addr_reg_r[31:1], 1'b0};
    assign misaligned_s = !addr_full_r || ((C_EXT == 1'b0) && addr_reg_r[1]);
    assign addr_wr_en_s = addr_en && !addr_full_r && !commit;
    assign load_s       = stream_start && !commit;
    assign advance_s    = (state_r == STREAM) && stream_en && !commit && !stream_start;

    // Merge the incoming subword into the slot selected by addr_cnt.
    always_comb begin
        addr_wr_s = addr_reg_r;
        for (int i = 0; i < N_SUB; i++) begin
            if (addr_cnt_r == CW'(i)) begin
                addr_wr_s[i*P_NBITS +: P_NBITS] = addr_in;
            end else begin
                addr_wr_s[i*P_NBITS +: P_NBITS] = addr_reg_r[i*P_NBITS +: P_NBITS];
            end
        end
    end

    // Target deserializer; commit rewinds the counter but keeps the captured value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg_r  <= 32'd0;
            addr_cnt_r  <= '0;
            addr_full_r <= 1'b0;
        end else if (commit) begin
            addr_cnt_r  <= '0;
            addr_full_r <= 1'b0;
        end else if (addr_wr_en_s) begin
            addr_reg_r  <= addr_wr_s;
            addr_full_r <= (addr_cnt_r == LAST_IDX);
            addr_cnt_r  <= (addr_cnt_r == LAST_IDX) ? '0 : addr_cnt_r + CW'(1);
        end else begin
            addr_reg_r  <= addr_reg_r;
            addr_cnt_r  <= addr_cnt_r;
            addr_full_r <= addr_full_r;
        end
    end

    // Architectural PC update and misaligned-target rejection pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_VECTOR;
            misalign_r <= 1'b0;
        end else begin
            if (commit && !commit_sel) begin
                pc_r <= pc_plus4_s;
            end else if (commit && commit_sel && !misaligned_s) begin
                pc_r <= target_s;
            end else begin
                pc_r <= pc_r;
            end
            misalign_r <= commit && commit_sel && misaligned_s;
        end
    end

    // Stream FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stream FSM next state; commit always wins over a same-cycle start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (commit) begin
                    state_nxt_s = IDLE;
                end else if (stream_start) begin
                    state_nxt_s = STREAM;
                end else if (stream_en && (count_r == LAST_IDX)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Snapshot shift registers; the snapshot uses the pre-commit PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_pc_r  <= 32'd0;
            sh_pc4_r <= 32'd0;
            count_r  <= '0;
        end else if (load_s) begin
            sh_pc_r  <= pc_r;
            sh_pc4_r <= pc_plus4_s;
            count_r  <= '0;
        end else if (advance_s) begin
            sh_pc_r  <= rotr(sh_pc_r);
            sh_pc4_r <= rotr(sh_pc4_r);
            count_r  <= count_r + CW'(1);
        end else begin
            sh_pc_r  <= sh_pc_r;
            sh_pc4_r <= sh_pc4_r;
            count_r  <= count_r;
        end
    end

    // Serial output mux, forced to zero outside a stream.
    always_comb begin
        stream_out = '0;
        if (state_r == STREAM) begin
            if (stream_sel) begin
                stream_out = sh_pc4_r[P_NBITS-1:0];
            end else begin
                stream_out = sh_pc_r[P_NBITS-1:0];
            end
        end else begin
            stream_out = '0;
        end
    end

    assign stream_busy  = (state_r == STREAM);
    assign stream_last  = (state_r == STREAM) && stream_en && (count_r == LAST_IDX);
    assign pc           = pc_r;
    assign addr_full    = addr_full_r;
    assign addr_reg     = addr_reg_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_param_pc_serial_unit.sv
// Bench for param_pc_serial_unit: instances 0/1 are P=4 with C_EXT 0/1, instances 2..5 sweep P=1,2,8,32.
module tb_param_pc_serial_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, addr_en, commit, commit_sel, stream_sel;
    logic [3:0]  addr_in;
    logic [5:0]  ss, se;
    logic [31:0] pc_w [6];
    logic [31:0] so_w [6];
    logic [31:0] areg_w [6];
    logic [5:0]  busy_w, last_w, full_w, err_w;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int P = (g == 2) ? 1 : (g == 3) ? 2 : (g == 4) ? 8 : (g == 5) ? 32 : 4;
        logic [P-1:0] so;
        logic [P-1:0] ain;
        assign ain     = (g < 2) ? P'(addr_in) : '0;
        assign so_w[g] = 32'(so);
        param_pc_serial_unit #(.P_NBITS(P), .RESET_VECTOR(32'h00080000), .C_EXT(g == 1)) u_dut (
            .clk(clk), .reset(reset),
            .addr_en((g < 2) ? addr_en : 1'b0), .addr_in(ain),
            .stream_start(ss[g]), .stream_en(se[g]), .stream_sel(stream_sel),
            .commit((g < 2) ? commit : 1'b0), .commit_sel(commit_sel),
            .pc(pc_w[g]), .stream_out(so), .stream_busy(busy_w[g]), .stream_last(last_w[g]),
            .addr_full(full_w[g]), .addr_reg(areg_w[g]), .misalign_err(err_w[g])
        );
    end

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] sub;
        logic        last;
    } sexp_t;

    typedef struct {
        logic [31:0] target;
        logic        sel;
        int          nsub;
        logic        extra;
        logic [31:0] exp_pc0;
        logic        exp_err0;
        logic [31:0] exp_pc1;
        logic        exp_err1;
    } vec_t;

    sexp_t sq [$];
    vec_t  cq [$];
    vec_t  tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic stream_check(input int d, input int p, input logic [31:0] pcv, input logic sel);
        int          n;
        logic [31:0] mask, v;
        sexp_t       e;
        n    = 32 / p;
        mask = (p == 32) ? 32'hFFFFFFFF : ((32'd1 << p) - 32'd1);
        v    = sel ? pcv + 32'd4 : pcv;
        @(negedge clk);
        stream_sel = sel;
        ss[d] = 1'b1;
        @(negedge clk);
        ss[d] = 1'b0;
        chk($sformatf("busy_start[%0d]", d), 32'(busy_w[d]), 32'd1);
        for (int k = 0; k < n; k++) begin
            se[d]  = 1'b1;
            e.sub  = (v >> (k * p)) & mask;
            e.last = (k == n - 1);
            sq.push_back(e);
            #1;
            e = sq.pop_front();
            chk($sformatf("stream_out[%0d] k=%0d", d, k), so_w[d], e.sub);
            chk($sformatf("stream_last[%0d] k=%0d", d, k), 32'(last_w[d]), 32'(e.last));
            @(negedge clk);
        end
        se[d] = 1'b0;
        #1;
        chk($sformatf("busy_end[%0d]", d), 32'(busy_w[d]), 32'd0);
        chk($sformatf("idle_out[%0d]", d), so_w[d], 32'd0);
    endtask

    task automatic feed(input logic [31:0] t, input int nsub);
        for (int i = 0; i < nsub; i++) begin
            @(negedge clk);
            addr_en = 1'b1;
            addr_in = t[i*4 +: 4];
        end
        @(negedge clk);
        addr_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{32'h00001234, 1'b1, 8, 1'b0, 32'h00001234, 1'b0, 32'h00001234, 1'b0};
        tbl[1] = '{32'h00001236, 1'b1, 8, 1'b0, 32'h00001234, 1'b1, 32'h00001236, 1'b0};
        tbl[2] = '{32'h00000000, 1'b0, 0, 1'b0, 32'h00001238, 1'b0, 32'h0000123A, 1'b0};
        tbl[3] = '{32'hABCD0001, 1'b1, 8, 1'b1, 32'hABCD0000, 1'b0, 32'hABCD0000, 1'b0};
        tbl[4] = '{32'h55555557, 1'b1, 3, 1'b0, 32'hABCD0000, 1'b1, 32'hABCD0000, 1'b1};
        tbl[5] = '{32'hFFFFFFFC, 1'b1, 8, 1'b0, 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0};
        tbl[6] = '{32'h00000000, 1'b0, 0, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tbl[7] = '{32'h00000003, 1'b1, 8, 1'b0, 32'h00000000, 1'b1, 32'h00000002, 1'b0};

        reset = 1'b1; addr_en = 1'b0; addr_in = 4'd0; commit = 1'b0; commit_sel = 1'b0;
        stream_sel = 1'b0; ss = 6'd0; se = 6'd0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_w[0], 32'h00080000);
        chk("rst_busy", 32'(busy_w), 32'd0);
        chk("rst_full", 32'(full_w), 32'd0);
        chk("rst_err", 32'(err_w), 32'd0);
        chk("rst_areg", areg_w[0], 32'd0);
        chk("rst_out", so_w[0], 32'd0);
        reset = 1'b0;

        stream_check(0, 4, 32'h00080000, 1'b0);
        stream_check(0, 4, 32'h00080000, 1'b1);
        stream_check(2, 1, 32'h00080000, 1'b0);
        stream_check(3, 2, 32'h00080000, 1'b0);
        stream_check(4, 8, 32'h00080000, 1'b0);
        stream_check(5, 32, 32'h00080000, 1'b0);

        for (int r = 0; r < 8; r++) begin
            v = tbl[r];
            feed(v.target, v.nsub);
            if (v.nsub == 8) begin
                chk($sformatf("addr_full r%0d", r), 32'(full_w[0]), 32'd1);
                chk($sformatf("addr_reg r%0d", r), areg_w[0], v.target);
            end
            if (v.extra) begin
                addr_en = 1'b1; addr_in = 4'hF;
                @(negedge clk);
                addr_en = 1'b0;
                chk($sformatf("addr_hold r%0d", r), areg_w[0], v.target);
            end
            commit = 1'b1; commit_sel = v.sel;
            cq.push_back(v);
            @(negedge clk);
            commit = 1'b0; commit_sel = 1'b0;
            v = cq.pop_front();
            chk($sformatf("pc0 r%0d", r), pc_w[0], v.exp_pc0);
            chk($sformatf("err0 r%0d", r), 32'(err_w[0]), 32'(v.exp_err0));
            chk($sformatf("pc1 r%0d", r), pc_w[1], v.exp_pc1);
            chk($sformatf("err1 r%0d", r), 32'(err_w[1]), 32'(v.exp_err1));
            chk($sformatf("full_clr r%0d", r), 32'(full_w[0]), 32'd0);
            @(negedge clk);
            chk($sformatf("err_pulse r%0d", r), 32'(err_w[1:0]), 32'd0);
        end

        // commit beats a simultaneous stream_start
        ss[0] = 1'b1; commit = 1'b1; commit_sel = 1'b0;
        @(negedge clk);
        ss[0] = 1'b0; commit = 1'b0;
        chk("prio_busy", 32'(busy_w[0]), 32'd0);
        chk("prio_pc", pc_w[0], 32'h00000004);

        // reset on the 4th stream_en, with a partially deserialized target
        ss[0] = 1'b1;
        @(negedge clk);
        ss[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            se[0] = 1'b1; addr_en = 1'b1; addr_in = 4'h9;
            @(negedge clk);
        end
        se[0] = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc_w[0], 32'h00080000);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_areg", areg_w[0], 32'd0);
        @(negedge clk);
        reset = 1'b0; se[0] = 1'b0; addr_en = 1'b0;
        stream_check(0, 4, 32'h00080000, 1'b0);
        feed(32'h00001234, 8);
        commit = 1'b1; commit_sel = 1'b1;
        @(negedge clk);
        commit = 1'b0; commit_sel = 1'b0;
        chk("post_rst_pc", pc_w[0], 32'h00001234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/param_pc_serial_unit.md
PARAM_PC_SERIAL_UNIT -- requirements
Module: param_pc_serial_unit

Interface
REQ-001 SHALL provide parameter P_NBITS, default 4, serial subword width; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h00080000, PC value loaded on reset.
REQ-003 SHALL provide parameter C_EXT, default 0; 1 permits 2-byte-aligned targets.
REQ-004 SHALL derive localparam N_SUB = 32/P_NBITS and use a subword counter width of max(1, clog2(N_SUB)).
REQ-005 clk  in  1  sole clock, all state on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 addr_en  in  1  accept one target subword this cycle.
REQ-008 addr_in  in  P_NBITS  target subword, LSB-first order.
REQ-009 stream_start  in  1  load PC snapshot into shift registers and begin a stream.
REQ-010 stream_en  in  1  advance the stream by one subword.
REQ-011 stream_sel  in  1  0 = stream PC, 1 = stream PC+4.
REQ-012 commit  in  1  end-of-instruction PC update request.
REQ-013 commit_sel  in  1  0 = sequential (PC+4), 1 = target from address register.
REQ-014 pc  out  32  architectural PC.
REQ-015 stream_out  out  P_NBITS  current serial subword of selected stream.
REQ-016 stream_busy  out  1  stream in progress.
REQ-017 stream_last  out  1  stream_out is final subword (combinational, only with stream_en).
REQ-018 addr_full  out  1  all N_SUB target subwords captured.
REQ-019 addr_reg  out  32  deserialized target.
REQ-020 misalign_err  out  1  one-cycle pulse, rejected misaligned target commit.

Function
REQ-021 Address register SHALL write addr_in into subword index addr_cnt on addr_en, increment addr_cnt, set addr_full when the write hits index N_SUB-1.
REQ-022 addr_en while addr_full=1 SHALL be ignored; addr_reg and addr_cnt SHALL hold.
REQ-023 Any commit SHALL clear addr_cnt and addr_full next cycle; addr_reg value SHALL be retained.
REQ-024 Effective target SHALL be {addr_reg[31:1], 1'b0}.
REQ-025 commit with commit_sel=0 SHALL load pc <= pc+4 (mod 2^32, wrap 32'hFFFFFFFC -> 0).
REQ-026 commit with commit_sel=1 and addr_full=1 SHALL load effective target, unless C_EXT=0 and target bit1=1: then pc SHALL hold and misalign_err SHALL pulse next cycle.
REQ-027 commit with commit_sel=1 and addr_full=0 SHALL be treated as misaligned: pc holds, misalign_err pulses.
REQ-028 Stream FSM SHALL have states IDLE and STREAM; IDLE->STREAM on stream_start; STREAM->IDLE on stream_en with count=N_SUB-1, or on commit.
REQ-029 On stream_start SHALL load sh_pc <= pc and sh_pc4 <= pc+4, count <= 0, using pc value before any same-cycle commit.
REQ-030 In STREAM, stream_en SHALL rotate both shift registers right by P_NBITS and increment count; stream_out = stream_sel ? sh_pc4[P_NBITS-1:0] : sh_pc[P_NBITS-1:0].
REQ-031 stream_start in STREAM SHALL restart the stream (reload, count <= 0).
REQ-032 commit and stream_start together: commit SHALL take priority; FSM -> IDLE, no reload.
REQ-033 stream_busy SHALL equal (state==STREAM); stream_out SHALL be 0 in IDLE.
REQ-034 P_NBITS=32 SHALL yield single-subword stream: stream_last on first stream_en.

Reset
REQ-035 Asynchronous reset SHALL set pc=RESET_VECTOR, addr_reg=0, addr_cnt=0, addr_full=0, shift regs=0, count=0, state=IDLE, misalign_err=0.
REQ-036 Reset asserted mid-stream or mid-deserialization SHALL abort immediately; first accepted event after deassertion SHALL see reset values.

Verification
REQ-037 Reset, then stream_start, stream_sel=0, 8x stream_en (P=4) -> stream_out 0,0,0,0,8,0,0,0; stream_last on 8th only; busy falls after.
REQ-038 8x addr_in feeding 32'h00001234 then commit, commit_sel=1 -> pc=32'h00001234, addr_full cleared.
REQ-039 Target 32'h00001236, C_EXT=0 -> pc unchanged, misalign_err one pulse; same with C_EXT=1 -> pc=32'h00001236.
REQ-040 pc=32'hFFFFFFFC, commit, commit_sel=0 -> pc=0.
REQ-041 commit, commit_sel=1 after 3 subwords only -> misalign_err, pc unchanged, addr_cnt=0.
REQ-042 Assert reset at 4th stream_en -> pc=32'h00080000, stream_busy=0 immediately; sweep P_NBITS 1/2/8/32 with the REQ-037 check.
